// File: rtl/pbvi_backup_seq_if.sv
// Result stream from the PBVI backup unit to the step-3 consumer.
// One transfer per (belief, action) pair, valid/ready handshake.
interface pbvi_backup_seq_if #(
  parameter int N_ACT    = 3,
  parameter int N_OBS    = 2,
  parameter int N_ALPHA  = 16,
  parameter int N_STATE  = 2,
  parameter int N_BELIEF = 16,
  parameter int DW       = 16
);
  // Index widths are clamped to 1 bit so single-entry dimensions stay legal.
  localparam int BIW = (N_BELIEF > 1) ? $clog2(N_BELIEF) : 1;
  localparam int AIW = (N_ACT > 1) ? $clog2(N_ACT) : 1;
  localparam int JW  = $clog2(N_ALPHA);

  logic                    out_valid;
  logic                    out_ready;
  logic [BIW-1:0]          out_belief_idx;
  logic [AIW-1:0]          out_act_idx;
  logic [N_STATE*DW-1:0]   out_vec;
  logic [N_OBS*JW-1:0]     out_best_idx;

  modport master (
    output out_valid,
    output out_belief_idx,
    output out_act_idx,
    output out_vec,
    output out_best_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_belief_idx,
    input  out_act_idx,
    input  out_vec,
    input  out_best_idx,
    output out_ready
  );
endinterface

// File: rtl/pbvi_backup_seq.sv
// Time-multiplexed point-based value backup: for each belief b and action a,
// pick per observation the alpha with the largest dot product against b, then
// emit reward[a] plus the selected alphas over a valid/ready stream.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; counters parked at 0
// SCAN  | one alpha per cycle, observation-major, running argmax
// SUM   | reward + selected alphas registered onto the output fields
// OUT   | out_valid high; handshake advances action, then belief
module pbvi_backup_seq #(
  parameter int N_ACT    = 3,
  parameter int N_OBS    = 2,
  parameter int N_ALPHA  = 16,
  parameter int N_STATE  = 2,
  parameter int N_BELIEF = 16,
  parameter int DW       = 16,
  parameter int FRAC     = 16,
  parameter int SAT      = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [N_ACT*N_OBS*N_ALPHA*N_STATE*DW-1:0] alpha_flat,
  input  logic [N_ACT*N_STATE*DW-1:0]            reward_flat,
  input  logic [N_BELIEF*N_STATE*DW-1:0]         belief_flat,
  output logic                                   busy,
  output logic                                   done,
  pbvi_backup_seq_if.master                      out_if
);

  localparam int BIW = (N_BELIEF > 1) ? $clog2(N_BELIEF) : 1;
  localparam int AIW = (N_ACT > 1) ? $clog2(N_ACT) : 1;
  localparam int OIW = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int JW  = $clog2(N_ALPHA);
  // Full-precision dot product: DW*DW products summed over N_STATE terms.
  localparam int PW  = 2*DW + $clog2(N_STATE);
  // Final sum: reward plus N_OBS alphas, with headroom to detect overflow.
  localparam int SW  = DW + $clog2(N_OBS + 1) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SUM  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [BIW-1:0] b_idx;
  logic [AIW-1:0] a_idx;
  logic [OIW-1:0] o_idx;
  logic [JW-1:0]  j_idx;

  logic [DW-1:0]  best_dot [N_OBS];
  logic [JW-1:0]  best_idx [N_OBS];

  logic [PW-1:0]  dot_acc;
  logic [PW-1:0]  dot_shift;
  logic [DW-1:0]  dot_sat;

  logic [SW-1:0]          sum_acc;
  logic [N_STATE*DW-1:0]  sum_vec;
  logic [N_OBS*JW-1:0]    best_pack;

  logic scan_last;
  logic act_last;
  logic bel_last;
  logic pair_last;
  logic xfer;

  assign scan_last = (o_idx == OIW'(N_OBS - 1)) && (j_idx == JW'(N_ALPHA - 1));
  assign act_last  = (a_idx == AIW'(N_ACT - 1));
  assign bel_last  = (b_idx == BIW'(N_BELIEF - 1));
  assign pair_last = act_last && bel_last;
  assign xfer      = (state == OUT) && out_if.out_ready;

  assign busy             = (state != IDLE);
  assign out_if.out_valid = (state == OUT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = SUM;
      SUM:     state_nxt = OUT;
      OUT:     if (xfer) state_nxt = pair_last ? IDLE : SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan counters (obs-major, alpha index minor) and the (b,a) pair counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_idx <= '0;
      a_idx <= '0;
      o_idx <= '0;
      j_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b_idx <= '0;
            a_idx <= '0;
            o_idx <= '0;
            j_idx <= '0;
          end
        end
        SCAN: begin
          if (j_idx == JW'(N_ALPHA - 1)) begin
            j_idx <= '0;
            o_idx <= (o_idx == OIW'(N_OBS - 1)) ? '0 : o_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
        end
        OUT: begin
          if (xfer) begin
            if (act_last) begin
              a_idx <= '0;
              b_idx <= bel_last ? '0 : b_idx + 1'b1;
            end else begin
              a_idx <= a_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Dot product of the alpha under the scan pointer with the current belief,
  // scaled by FRAC and clamped to DW bits.
  always_comb begin
    dot_acc = '0;
    for (int s = 0; s < N_STATE; s++) begin
      dot_acc = dot_acc
        + PW'(alpha_flat[((((int'(a_idx) * N_OBS + int'(o_idx)) * N_ALPHA + int'(j_idx))
                           * N_STATE + s) * DW) +: DW])
        * PW'(belief_flat[((int'(b_idx) * N_STATE + s) * DW) +: DW]);
    end
    dot_shift = dot_acc >> FRAC;
    if (|(dot_shift >> DW)) dot_sat = '1;
    else                    dot_sat = dot_shift[DW-1:0];
  end

  // Running argmax per observation; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_OBS; o++) begin
        best_dot[o] <= '0;
        best_idx[o] <= '0;
      end
    end else if (state == SCAN) begin
      if ((j_idx == '0) || (dot_sat > best_dot[o_idx])) begin
        best_dot[o_idx] <= dot_sat;
        best_idx[o_idx] <= j_idx;
      end
    end
  end

  // Reward plus the winning alpha of every observation, wrapped or saturated.
  always_comb begin
    sum_vec = '0;
    sum_acc = '0;
    for (int s = 0; s < N_STATE; s++) begin
      sum_acc = SW'(reward_flat[((int'(a_idx) * N_STATE + s) * DW) +: DW]);
      for (int o = 0; o < N_OBS; o++) begin
        sum_acc = sum_acc
          + SW'(alpha_flat[((((int'(a_idx) * N_OBS + o) * N_ALPHA + int'(best_idx[o]))
                             * N_STATE + s) * DW) +: DW]);
      end
      if ((SAT != 0) && (|(sum_acc >> DW))) sum_vec[s*DW +: DW] = '1;
      else                                  sum_vec[s*DW +: DW] = sum_acc[DW-1:0];
    end
  end

  // Pack the winning indices, observation o at field o.
  always_comb begin
    best_pack = '0;
    for (int o = 0; o < N_OBS; o++) begin
      best_pack[o*JW +: JW] = best_idx[o];
    end
  end

  // Output fields load in SUM and hold through OUT, including under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_if.out_vec        <= '0;
      out_if.out_best_idx   <= '0;
      out_if.out_belief_idx <= '0;
      out_if.out_act_idx    <= '0;
    end else if (state == SUM) begin
      out_if.out_vec        <= sum_vec;
      out_if.out_best_idx   <= best_pack;
      out_if.out_belief_idx <= b_idx;
      out_if.out_act_idx    <= a_idx;
    end
  end

  // Completion pulse in the cycle after the final handshake (state is IDLE then).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= xfer && pair_last;
  end

endmodule

// File: tb/tb_pbvi_backup_seq.sv
// Directed bench for pbvi_backup_seq at default parameters. A second instance
// with SAT=1 runs in lockstep on the same inputs to cover saturation.
module tb_pbvi_backup_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3*2*16*2*16-1:0] alpha_flat  = '0;
  logic [3*2*16-1:0]      reward_flat = '0;
  logic [16*2*16-1:0]     belief_flat = '0;
  logic busy, done, busy_s, done_s;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_vec [3];
  logic [31:0] exp_sat [3];
  logic [7:0]  exp_best;

  pbvi_backup_seq_if ifc ();
  pbvi_backup_seq_if ifc_s ();

  pbvi_backup_seq #(.SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alpha_flat(alpha_flat), .reward_flat(reward_flat), .belief_flat(belief_flat),
    .busy(busy), .done(done), .out_if(ifc)
  );

  pbvi_backup_seq #(.SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alpha_flat(alpha_flat), .reward_flat(reward_flat), .belief_flat(belief_flat),
    .busy(busy_s), .done(done_s), .out_if(ifc_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_alpha(input int a, input int o, input int j,
                           input logic [15:0] v0, input logic [15:0] v1);
    alpha_flat[(((a*2+o)*16+j)*2+0)*16 +: 16] = v0;
    alpha_flat[(((a*2+o)*16+j)*2+1)*16 +: 16] = v1;
  endtask

  task automatic set_reward(input int a, input logic [15:0] v0, input logic [15:0] v1);
    reward_flat[(a*2+0)*16 +: 16] = v0;
    reward_flat[(a*2+1)*16 +: 16] = v1;
  endtask

  task automatic set_beliefs(input logic [15:0] v0, input logic [15:0] v1);
    for (int b = 0; b < 16; b++) begin
      belief_flat[(b*2+0)*16 +: 16] = v0;
      belief_flat[(b*2+1)*16 +: 16] = v1;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (ifc.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("out_valid_seen", {63'd0, ifc.out_valid}, 64'd1);
  endtask

  // Full pass with out_ready high; optional 10-cycle stall on the first result
  // and optional start held high while busy.
  task automatic run_pass(input bit bp, input bit poke);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 3; a++) begin
        wait_valid(n);
        chk($sformatf("latency b%0d a%0d", b, a), 64'(n), 64'd33);
        chk($sformatf("bidx b%0d a%0d", b, a), 64'(ifc.out_belief_idx), 64'(b));
        chk($sformatf("aidx b%0d a%0d", b, a), 64'(ifc.out_act_idx), 64'(a));
        chk($sformatf("vec b%0d a%0d", b, a), 64'(ifc.out_vec), 64'(exp_vec[a]));
        chk($sformatf("best b%0d a%0d", b, a), 64'(ifc.out_best_idx), 64'(exp_best));
        chk($sformatf("satvec b%0d a%0d", b, a), 64'(ifc_s.out_vec), 64'(exp_sat[a]));
        chk($sformatf("done_low b%0d a%0d", b, a), {63'd0, done}, 64'd0);
        if (bp && b == 0 && a == 0) begin
          ifc.out_ready   = 1'b0;
          ifc_s.out_ready = 1'b0;
          for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid", {63'd0, ifc.out_valid}, 64'd1);
            chk("bp_busy", {63'd0, busy}, 64'd1);
            chk("bp_vec", 64'(ifc.out_vec), 64'(exp_vec[0]));
            chk("bp_bidx", 64'(ifc.out_belief_idx), 64'd0);
            chk("bp_aidx", 64'(ifc.out_act_idx), 64'd0);
          end
          ifc.out_ready   = 1'b1;
          ifc_s.out_ready = 1'b1;
        end
        if (poke) start = (b == 15 && a == 2) ? 1'b0 : 1'b1;
        tick();
        if (!(b == 15 && a == 2)) begin
          chk("post_xfer_valid", {63'd0, ifc.out_valid}, 64'd0);
          chk("post_xfer_busy", {63'd0, busy}, 64'd1);
        end
      end
    end
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("done_valid_excl", {63'd0, ifc.out_valid}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("no_restart", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    ifc.out_ready   = 1'b1;
    ifc_s.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_vec", 64'(ifc.out_vec), 64'd0);
    chk("rst_best", 64'(ifc.out_best_idx), 64'd0);
    chk("rst_bidx", 64'(ifc.out_belief_idx), 64'd0);
    chk("rst_aidx", 64'(ifc.out_act_idx), 64'd0);
    rst_n = 1'b1;
    tick();

    // Zero alphas, reward 5 everywhere: every result is {5,5}, best 0.
    for (int b = 0; b < 16; b++) begin
      belief_flat[(b*2+0)*16 +: 16] = 16'(b * 16'h0111);
      belief_flat[(b*2+1)*16 +: 16] = 16'(16'h8000 - b);
    end
    for (int a = 0; a < 3; a++) set_reward(a, 16'd5, 16'd5);
    exp_vec[0] = 32'h0005_0005; exp_vec[1] = 32'h0005_0005; exp_vec[2] = 32'h0005_0005;
    exp_sat[0] = 32'h0005_0005; exp_sat[1] = 32'h0005_0005; exp_sat[2] = 32'h0005_0005;
    exp_best = 8'h00;
    run_pass(1'b0, 1'b0);

    // Ramp alphas j*0x100 against belief 0x8000: dot = j*0x100, best 15.
    set_beliefs(16'h8000, 16'h8000);
    for (int a = 0; a < 3; a++) begin
      set_reward(a, 16'(a * 16'h100 + 1), 16'(a * 16'h100 + 2));
      for (int o = 0; o < 2; o++)
        for (int j = 0; j < 16; j++)
          set_alpha(a, o, j, 16'(j * 16'h100), 16'(j * 16'h100));
    end
    exp_vec[0] = 32'h1E02_1E01; exp_vec[1] = 32'h1F02_1F01; exp_vec[2] = 32'h2002_2001;
    exp_sat[0] = 32'h1E02_1E01; exp_sat[1] = 32'h1F02_1F01; exp_sat[2] = 32'h2002_2001;
    exp_best = 8'hFF;
    run_pass(1'b1, 1'b0);

    // Tie between alpha 3 and alpha 9: lowest index wins; start held while busy.
    for (int a = 0; a < 3; a++)
      for (int o = 0; o < 2; o++)
        for (int j = 0; j < 16; j++)
          if (j == 3 || j == 9) set_alpha(a, o, j, 16'h0800, 16'h0800);
          else                  set_alpha(a, o, j, 16'(j * 16'h10), 16'(j * 16'h10));
    exp_vec[0] = 32'h1002_1001; exp_vec[1] = 32'h1102_1101; exp_vec[2] = 32'h1202_1201;
    exp_sat[0] = 32'h1002_1001; exp_sat[1] = 32'h1102_1101; exp_sat[2] = 32'h1202_1201;
    exp_best = 8'h33;
    run_pass(1'b0, 1'b1);

    // Overflow: 0xFFFF + 1 + 1 wraps to 1, saturates to 0xFFFF.
    for (int a = 0; a < 3; a++) begin
      set_reward(a, 16'hFFFF, 16'hFFFF);
      for (int o = 0; o < 2; o++)
        for (int j = 0; j < 16; j++)
          set_alpha(a, o, j, 16'h0001, 16'h0001);
    end
    exp_vec[0] = 32'h0001_0001; exp_vec[1] = 32'h0001_0001; exp_vec[2] = 32'h0001_0001;
    exp_sat[0] = 32'hFFFF_FFFF; exp_sat[1] = 32'hFFFF_FFFF; exp_sat[2] = 32'hFFFF_FFFF;
    exp_best = 8'h00;
    run_pass(1'b0, 1'b0);

    // Abort mid-SCAN with reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("scan_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("abort_vec", 64'(ifc.out_vec), 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    tick();
    chk("abort_done_hold", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("after_abort_busy", {63'd0, busy}, 64'd0);
      chk("after_abort_done", {63'd0, done}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
